board_turn_ctrl: RTL and testbench
==================================

Name: board_turn_ctrl

Overview:
- Upstream stage of the tic-tac-toe game-over checker. Owns the 3x3 board registers, the side-to-move flag and the per-turn BCD countdown timer.
- Accepts move requests and places marks; freezes when the checker reports an end or the board is full.
- Outputs connect 1:1 to the checker's b0..b8, whosTurn, tenDigit and UnitDigit inputs. The checker's gameend is fed back in.

Parameters:
- TICK_DIV, 50000000: clk cycles per timer second. The bench uses 4.
- TURN_SECONDS, 30: per-turn start value, decimal, legal range 1..99. Loaded as BCD (tens = TURN_SECONDS/10, units = TURN_SECONDS%10).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- new_game  in  1  synchronous restart, same effect as rst
- move_valid  in  1  single-cycle move request
- move_pos  in  4  target cell 0..8, row-major
- gameend  in  2  from checker: 00 running, 01 player-1 win, 10 player-2 win
- b0..b8  out  2 each  cell state: 00 empty, 01 player 1, 10 player 2, 11 never driven
- whosTurn  out  1  0 = player 1 (mark 01) to move, 1 = player 2 (mark 10)
- tenDigit  out  4  BCD tens of remaining seconds
- UnitDigit  out  4  BCD units of remaining seconds
- move_ack  out  1  1-cycle pulse: move accepted
- move_err  out  1  1-cycle pulse: move rejected
- draw  out  1  level, board full with gameend==00
- over  out  1  level, high in OVER state

Behaviour:
- Reset (rst or new_game, either state): all cells 00, whosTurn 0, digits = TURN_SECONDS BCD, prescaler 0, move_ack/move_err/draw 0, state PLAY.
- Reset has priority over everything else.
- States:
  - PLAY -> OVER when gameend!=00, or when all nine cells are non-zero. In the full-board case, set draw=1 if gameend==00.
  - OVER -> PLAY only via rst or new_game.
- Move handling in PLAY:
  - A move is accepted when move_valid=1, move_pos<=8, the target cell is 00, the timer is not 00, and gameend==00 in that cycle.
  - On accept, on the next edge:
    - cell <= (whosTurn ? 10 : 01)
    - whosTurn toggles
    - digits reload to TURN_SECONDS
    - prescaler clears
    - move_ack=1 for one cycle
  - Any other move_valid in PLAY gives move_err=1 for one cycle with no state change.
  - move_valid in OVER gives move_err=1 for one cycle.
- Timer, PLAY only:
  - The prescaler counts 0..TICK_DIV-1. On wrap, the BCD value decrements.
  - If units!=0, units is decremented. If units==0 and tens!=0, units becomes 9 and tens is decremented.
  - At 00 the timer holds, the prescaler stops, and whosTurn does not change. The checker decides the outcome from the 00 digits.
  - The digits are never outside 0..9.
- Simultaneous events:
  - An accepted move in the same cycle as a tick: the move wins (reload; the decrement is dropped).
  - Move with gameend!=00 in the same cycle: rejected, and the state goes to OVER.
  - The last empty cell filled: accepted; OVER is entered on the following cycle.
- OVER: board, whosTurn and digits frozen; prescaler held.
- All outputs are registered. Latency from move_valid to the board/turn update is one clock.

Optional Feature:
- Macro: BOARD_UNDO_EN
- Defined:
  - Adds input undo (1 bit) and a one-entry last-move register (position plus valid bit).
  - An undo pulse in PLAY with the entry valid does the following: clears that cell, toggles whosTurn back, reloads the timer, clears the entry valid bit, and pulses move_ack.
  - Undo with no valid entry, or in OVER, pulses move_err.
  - Undo and move_valid in the same cycle: undo wins; the move is ignored with no err.
  - rst or new_game clears the entry valid bit.
- Undefined: no undo port; behaviour exactly as above.

Test Plan:
- Reset, then move_pos=4 valid: after 1 clk, b4=01, whosTurn=1, move_ack pulse, digits 3/0.
- Second move to pos 4: move_err pulse, b4 stays 01, whosTurn stays 1. move_pos=9: move_err pulse.
- TICK_DIV=4, TURN_SECONDS=12, no moves: digits go 1/2, 1/1, 1/0, 0/9 ... 0/0 every 4 clks, then hold 0/0 with whosTurn unchanged. A move at 0/0 gives move_err.
- Drive gameend=01 mid-game: over=1 next clk. A following move gives move_err with the board unchanged. new_game clears all cells, whosTurn=0, digits 3/0, over=0.
- Fill the board in a draw order with gameend held 00: the ninth move is acked, then over=1 and draw=1 on the next clk.
- BOARD_UNDO_EN: move pos 0, then undo: b0=00, whosTurn=0, move_ack. A second undo gives move_err.

Source files
------------

// File: rtl/board_turn_ctrl_if.sv
// ---------------------------------------------------------------------------
// board_turn_ctrl_if
//
// Purpose : Bundles the signals between the tic-tac-toe board/turn controller
//           and the surrounding logic: move-request handshake, restart and the
//           checker bus (board cells, side to move, BCD timer digits,
//           gameend feedback, status levels).
//
// Optional: BOARD_UNDO_EN adds the 'undo' request line.
//
// Signals :
//   new_game   -> ctrl  synchronous restart
//   move_valid -> ctrl  single-cycle move request
//   move_pos   -> ctrl  target cell 0..8, row-major
//   gameend    -> ctrl  checker verdict: 00 running, 01 p1 win, 10 p2 win
//   undo       -> ctrl  undo last move (BOARD_UNDO_EN only)
//   b0..b8     <- ctrl  cell state: 00 empty, 01 player 1, 10 player 2
//   whosTurn   <- ctrl  0 = player 1 to move, 1 = player 2 to move
//   tenDigit   <- ctrl  BCD tens of remaining seconds
//   UnitDigit  <- ctrl  BCD units of remaining seconds
//   move_ack   <- ctrl  1-cycle pulse, request accepted
//   move_err   <- ctrl  1-cycle pulse, request rejected
//   draw       <- ctrl  level, board full with no winner
//   over       <- ctrl  level, game frozen
//
// Modports: slave = controller side, master = driver/checker side.
// ---------------------------------------------------------------------------
interface board_turn_ctrl_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic [1:0] gameend;
`ifdef BOARD_UNDO_EN
    logic       undo;
`endif
    logic [1:0] b0;
    logic [1:0] b1;
    logic [1:0] b2;
    logic [1:0] b3;
    logic [1:0] b4;
    logic [1:0] b5;
    logic [1:0] b6;
    logic [1:0] b7;
    logic [1:0] b8;
    logic       whosTurn;
    logic [3:0] tenDigit;
    logic [3:0] UnitDigit;
    logic       move_ack;
    logic       move_err;
    logic       draw;
    logic       over;

    modport slave (
        input  new_game, move_valid, move_pos, gameend,
`ifdef BOARD_UNDO_EN
        input  undo,
`endif
        output b0, b1, b2, b3, b4, b5, b6, b7, b8,
        output whosTurn, tenDigit, UnitDigit,
        output move_ack, move_err, draw, over
    );

    modport master (
        output new_game, move_valid, move_pos, gameend,
`ifdef BOARD_UNDO_EN
        output undo,
`endif
        input  b0, b1, b2, b3, b4, b5, b6, b7, b8,
        input  whosTurn, tenDigit, UnitDigit,
        input  move_ack, move_err, draw, over
    );
endinterface

// File: rtl/board_turn_ctrl.sv
// ---------------------------------------------------------------------------
// board_turn_ctrl
//
// Purpose : Upstream stage of the tic-tac-toe game-over checker. Holds the
//           3x3 board, the side-to-move flag and a per-turn BCD countdown.
//           Places marks for legal move requests, and freezes once the
//           checker reports a win or the board fills up.
//
// Parameters:
//   TICK_DIV     clk cycles per timer second
//   TURN_SECONDS per-turn start value (1..99), loaded as two BCD digits
//
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-high reset
//   bus  board_turn_ctrl_if.slave (move handshake + checker bus)
//
// Optional feature macro: BOARD_UNDO_EN
//   Adds an undo request and a one-entry last-move register so the most
//   recent move can be taken back while the game is still running.
// ---------------------------------------------------------------------------
module board_turn_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int TURN_SECONDS = 30
) (
    input  logic              clk,
    input  logic              rst,
    board_turn_ctrl_if.slave  bus
);

    localparam int         PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] TENS_INIT  = 4'(TURN_SECONDS / 10);
    localparam logic [3:0] UNITS_INIT = 4'(TURN_SECONDS % 10);

    typedef enum logic {PLAY, OVER} state_t;

    state_t        state_q;
    logic [1:0]    board_q [9];
    logic          whosTurn_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic [PW-1:0] presc_q;
    logic          ack_q;
    logic          err_q;
    logic          draw_q;
`ifdef BOARD_UNDO_EN
    logic [3:0]    lastPos_q;
    logic          lastValid_q;
`endif

    logic          boardFull;
    logic          timerZero;
    logic          cellEmpty;
    logic          moveAccept;
    logic          undoReq;
    logic [PW-1:0] presc_d;
    logic [3:0]    tens_d;
    logic [3:0]    units_d;

    // Request decode and free-running timer next-state. The timer value here
    // is what the counter does when nothing else happens this cycle; a move
    // or undo overrides it with a reload. At 00 everything holds so the
    // checker sees a stable timeout.
    always_comb begin
        boardFull = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board_q[i] == 2'b00) boardFull = 1'b0;
        end

        timerZero = (tens_q == 4'd0) && (units_q == 4'd0);

        cellEmpty = 1'b0;
        if (bus.move_pos <= 4'd8) cellEmpty = (board_q[bus.move_pos] == 2'b00);

        moveAccept = bus.move_valid && cellEmpty && !timerZero && (bus.gameend == 2'b00);

`ifdef BOARD_UNDO_EN
        undoReq = bus.undo;
`else
        undoReq = 1'b0;
`endif

        presc_d = presc_q;
        tens_d  = tens_q;
        units_d = units_q;
        if (!timerZero) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (units_q != 4'd0) begin
                    units_d = units_q - 4'd1;
                end else begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Single registered FSM: board, turn, timer, pulses and status levels.
    // Undo outranks a same-cycle move (the move is dropped silently), and an
    // accepted move outranks a same-cycle timer tick.
    always_ff @(posedge clk) begin
        if (rst || bus.new_game) begin
            state_q    <= PLAY;
            for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
            whosTurn_q <= 1'b0;
            tens_q     <= TENS_INIT;
            units_q    <= UNITS_INIT;
            presc_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            draw_q     <= 1'b0;
`ifdef BOARD_UNDO_EN
            lastPos_q   <= 4'd0;
            lastValid_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (bus.gameend != 2'b00) begin
                        state_q <= OVER;
                    end else if (boardFull) begin
                        state_q <= OVER;
                        draw_q  <= 1'b1;
                    end

`ifdef BOARD_UNDO_EN
                    if (undoReq && lastValid_q) begin
                        board_q[lastPos_q] <= 2'b00;
                        whosTurn_q  <= ~whosTurn_q;
                        tens_q      <= TENS_INIT;
                        units_q     <= UNITS_INIT;
                        presc_q     <= '0;
                        lastValid_q <= 1'b0;
                        ack_q       <= 1'b1;
                    end else
`endif
                    if (moveAccept && !undoReq) begin
                        board_q[bus.move_pos] <= whosTurn_q ? 2'b10 : 2'b01;
                        whosTurn_q <= ~whosTurn_q;
                        tens_q     <= TENS_INIT;
                        units_q    <= UNITS_INIT;
                        presc_q    <= '0;
                        ack_q      <= 1'b1;
`ifdef BOARD_UNDO_EN
                        lastPos_q   <= bus.move_pos;
                        lastValid_q <= 1'b1;
`endif
                    end else begin
                        presc_q <= presc_d;
                        tens_q  <= tens_d;
                        units_q <= units_d;
                        if (undoReq || bus.move_valid) err_q <= 1'b1;
                    end
                end

                OVER: begin
                    if (undoReq || bus.move_valid) err_q <= 1'b1;
                end

                default: state_q <= PLAY;
            endcase
        end
    end

    assign bus.b0        = board_q[0];
    assign bus.b1        = board_q[1];
    assign bus.b2        = board_q[2];
    assign bus.b3        = board_q[3];
    assign bus.b4        = board_q[4];
    assign bus.b5        = board_q[5];
    assign bus.b6        = board_q[6];
    assign bus.b7        = board_q[7];
    assign bus.b8        = board_q[8];
    assign bus.whosTurn  = whosTurn_q;
    assign bus.tenDigit  = tens_q;
    assign bus.UnitDigit = units_q;
    assign bus.move_ack  = ack_q;
    assign bus.move_err  = err_q;
    assign bus.draw      = draw_q;
    assign bus.over      = (state_q == OVER);

endmodule

// File: tb/tb_board_turn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_turn_ctrl
//
// Purpose : Directed bench for board_turn_ctrl. Instance A runs with a
//           30-second turn to exercise moves, rejection, checker-driven end,
//           restart and a full-board draw. Instance B runs with a 12-second
//           turn to walk the BCD countdown down to 00 and its hold.
//           Both use a 4-cycle timer second.
// Optional: BOARD_UNDO_EN enables the undo steps.
// ---------------------------------------------------------------------------
module tb_board_turn_ctrl;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    int   passCount  = 0;
    int   checkCount = 0;

    board_turn_ctrl_if ifA ();
    board_turn_ctrl_if ifB ();

    board_turn_ctrl #(.TICK_DIV(4), .TURN_SECONDS(30)) dutA (
        .clk (clk),
        .rst (rstA),
        .bus (ifA)
    );

    board_turn_ctrl #(.TICK_DIV(4), .TURN_SECONDS(12)) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (ifB)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one so outputs
    // are sampled away from the edge and new inputs land before the next one
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // All nine cells of instance A packed b0 first
    function automatic logic [31:0] boardA();
        return 32'({ifA.b0, ifA.b1, ifA.b2, ifA.b3, ifA.b4, ifA.b5, ifA.b6, ifA.b7, ifA.b8});
    endfunction

    // Timer digits of an instance packed as {tens, units}
    function automatic logic [31:0] digitsA();
        return 32'({ifA.tenDigit, ifA.UnitDigit});
    endfunction

    function automatic logic [31:0] digitsB();
        return 32'({ifB.tenDigit, ifB.UnitDigit});
    endfunction

    // Drives instance A with one move request for a single cycle and checks the ack
    task automatic playMove(input logic [3:0] pos, input string tag);
        ifA.move_valid = 1'b1;
        ifA.move_pos   = pos;
        applyStimulus(1);
        checkOutput(tag, 32'(ifA.move_ack), 32'd1);
    endtask

    // Linear directed sequence
    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        ifA.new_game = 1'b0; ifA.move_valid = 1'b0; ifA.move_pos = 4'd0; ifA.gameend = 2'b00;
        ifB.new_game = 1'b0; ifB.move_valid = 1'b0; ifB.move_pos = 4'd0; ifB.gameend = 2'b00;
`ifdef BOARD_UNDO_EN
        ifA.undo = 1'b0;
        ifB.undo = 1'b0;
`endif
        $display("[TB] reset");
        applyStimulus(2);
        checkOutput("rst_board",  boardA(), 32'd0);
        checkOutput("rst_turn",   32'(ifA.whosTurn), 32'd0);
        checkOutput("rst_digits", digitsA(), 32'h30);
        checkOutput("rst_over",   32'(ifA.over), 32'd0);
        checkOutput("rst_ack",    32'(ifA.move_ack), 32'd0);
        checkOutput("rst_err",    32'(ifA.move_err), 32'd0);
        checkOutput("rst_draw",   32'(ifA.draw), 32'd0);

        // First move to the centre lands in one clock
        rstA = 1'b0;
        playMove(4'd4, "mv4_ack");
        checkOutput("mv4_b4",     32'(ifA.b4), 32'd1);
        checkOutput("mv4_turn",   32'(ifA.whosTurn), 32'd1);
        checkOutput("mv4_digits", digitsA(), 32'h30);
        checkOutput("mv4_err",    32'(ifA.move_err), 32'd0);

        // Occupied cell and out-of-range cell are both refused
        ifA.move_pos = 4'd4;
        applyStimulus(1);
        checkOutput("occ_err",  32'(ifA.move_err), 32'd1);
        checkOutput("occ_ack",  32'(ifA.move_ack), 32'd0);
        checkOutput("occ_b4",   32'(ifA.b4), 32'd1);
        checkOutput("occ_turn", 32'(ifA.whosTurn), 32'd1);
        ifA.move_pos = 4'd9;
        applyStimulus(1);
        checkOutput("pos9_err",   32'(ifA.move_err), 32'd1);
        checkOutput("pos9_board", boardA(), 32'h00100);
        ifA.move_valid = 1'b0;
        applyStimulus(1);
        checkOutput("idle_err", 32'(ifA.move_err), 32'd0);

        // Prescaler now sits at its last count: move and tick collide, move wins
        playMove(4'd0, "mv0_ack");
        checkOutput("mv0_board",  boardA(), 32'h20100);
        checkOutput("mv0_digits", digitsA(), 32'h30);
        checkOutput("mv0_turn",   32'(ifA.whosTurn), 32'd0);

        // Checker reports player-1 win together with a move: refused, game ends
        $display("[TB] checker end");
        ifA.gameend    = 2'b01;
        ifA.move_valid = 1'b1;
        ifA.move_pos   = 4'd1;
        applyStimulus(1);
        checkOutput("ge_err",   32'(ifA.move_err), 32'd1);
        checkOutput("ge_over",  32'(ifA.over), 32'd1);
        checkOutput("ge_board", boardA(), 32'h20100);
        ifA.move_valid = 1'b0;
        applyStimulus(1);
        ifA.move_valid = 1'b1;
        ifA.move_pos   = 4'd2;
        applyStimulus(1);
        checkOutput("over_err",   32'(ifA.move_err), 32'd1);
        checkOutput("over_board", boardA(), 32'h20100);
        ifA.move_valid = 1'b0;
        applyStimulus(8);
        checkOutput("over_digits", digitsA(), 32'h30);
        checkOutput("over_turn",   32'(ifA.whosTurn), 32'd0);
        checkOutput("over_hold",   32'(ifA.over), 32'd1);

        // Restart clears everything
        ifA.new_game = 1'b1;
        ifA.gameend  = 2'b00;
        applyStimulus(1);
        ifA.new_game = 1'b0;
        checkOutput("ng_board",  boardA(), 32'd0);
        checkOutput("ng_turn",   32'(ifA.whosTurn), 32'd0);
        checkOutput("ng_digits", digitsA(), 32'h30);
        checkOutput("ng_over",   32'(ifA.over), 32'd0);

        // Draw: X O X / X O O / O X X
        $display("[TB] draw game");
        playMove(4'd0, "d1_ack");
        playMove(4'd1, "d2_ack");
        playMove(4'd2, "d3_ack");
        playMove(4'd4, "d4_ack");
        playMove(4'd3, "d5_ack");
        playMove(4'd5, "d6_ack");
        playMove(4'd7, "d7_ack");
        playMove(4'd6, "d8_ack");
        playMove(4'd8, "d9_ack");
        checkOutput("d9_over",  32'(ifA.over), 32'd0);
        checkOutput("d9_board", boardA(),
                    32'({2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01}));
        ifA.move_valid = 1'b0;
        applyStimulus(1);
        checkOutput("draw_over", 32'(ifA.over), 32'd1);
        checkOutput("draw_flag", 32'(ifA.draw), 32'd1);
        applyStimulus(1);
        checkOutput("draw_hold", 32'(ifA.draw), 32'd1);

`ifdef BOARD_UNDO_EN
        // Take back the only move, then a second undo has nothing to undo
        $display("[TB] undo");
        ifA.new_game = 1'b1;
        applyStimulus(1);
        ifA.new_game = 1'b0;
        playMove(4'd0, "u_mv_ack");
        ifA.move_valid = 1'b0;
        ifA.undo = 1'b1;
        applyStimulus(1);
        checkOutput("u_b0",   32'(ifA.b0), 32'd0);
        checkOutput("u_turn", 32'(ifA.whosTurn), 32'd0);
        checkOutput("u_ack",  32'(ifA.move_ack), 32'd1);
        applyStimulus(1);
        checkOutput("u2_err", 32'(ifA.move_err), 32'd1);
        checkOutput("u2_ack", 32'(ifA.move_ack), 32'd0);
        ifA.undo = 1'b0;
`endif

        // Countdown from 12 with a 4-cycle second
        $display("[TB] countdown");
        checkOutput("b_rst_digits", digitsB(), 32'h12);
        rstB = 1'b0;
        applyStimulus(3);
        checkOutput("b_pre_tick", digitsB(), 32'h12);
        applyStimulus(1);
        checkOutput("b_11", digitsB(), 32'h11);
        applyStimulus(4);
        checkOutput("b_10", digitsB(), 32'h10);
        applyStimulus(4);
        checkOutput("b_09", digitsB(), 32'h09);
        applyStimulus(4);
        checkOutput("b_08", digitsB(), 32'h08);
        applyStimulus(32);
        checkOutput("b_00", digitsB(), 32'h00);
        applyStimulus(8);
        checkOutput("b_hold",      digitsB(), 32'h00);
        checkOutput("b_hold_turn", 32'(ifB.whosTurn), 32'd0);
        ifB.move_valid = 1'b1;
        ifB.move_pos   = 4'd0;
        applyStimulus(1);
        ifB.move_valid = 1'b0;
        checkOutput("b_to_err",  32'(ifB.move_err), 32'd1);
        checkOutput("b_to_b0",   32'(ifB.b0), 32'd0);
        checkOutput("b_to_turn", 32'(ifB.whosTurn), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
